sub_result_bcd: RTL and testbench

Sequential signed-binary-to-BCD converter sitting directly downstream of `sub_top`. It accepts the `WIDTH`-bit signed difference and overflow flag, converts the magnitude to two BCD digits plus a sign using an iterative shift-add-3 (double-dabble) datapath, and presents the result to the seven-segment display stage over a valid/ready handshake. One conversion is in flight at a time.

---
 rtl/sub_result_bcd.sv | 136 +++++++++++++
 tb/tb_sub_result_bcd.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_result_bcd.sv
// Signed binary to two-digit BCD converter placed after sub_top.
// The magnitude is converted by shift-add-3 (double dabble), one bit per cycle.
// The result is held on a valid/ready handshake until the display stage takes it.
module sub_result_bcd #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [3:0]       out_tens,
  output logic [3:0]       out_ones,
  output logic             out_overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = WIDTH + 8;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_e;

  state_e          state_q, state_d;
  logic            sign_q, sign_d;
  logic [SW-1:0]   work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            out_sign_q, out_sign_d;
  logic [3:0]      out_tens_q, out_tens_d;
  logic [3:0]      out_ones_q, out_ones_d;
  logic            out_overflow_q, out_overflow_d;

  logic [WIDTH-1:0] neg_value;
  logic [SW-1:0]    work_adj;
  logic [SW-1:0]    work_shift;

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      sign_q         <= 1'b0;
      work_q         <= '0;
      cnt_q          <= '0;
      out_valid_q    <= 1'b0;
      out_sign_q     <= 1'b0;
      out_tens_q     <= '0;
      out_ones_q     <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sign_q         <= sign_d;
      work_q         <= work_d;
      cnt_q          <= cnt_d;
      out_valid_q    <= out_valid_d;
      out_sign_q     <= out_sign_d;
      out_tens_q     <= out_tens_d;
      out_ones_q     <= out_ones_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  // Next-state, conversion step and handshake decode.
  always_comb begin
    state_d        = state_q;
    sign_d         = sign_q;
    work_d         = work_q;
    cnt_d          = cnt_q;
    out_valid_d    = out_valid_q;
    out_sign_d     = out_sign_q;
    out_tens_d     = out_tens_q;
    out_ones_d     = out_ones_q;
    out_overflow_d = out_overflow_q;

    in_ready  = (state_q == IDLE) && !reset;
    neg_value = -in_value;

    // {bcd, mag} kept as one register so a single shift moves the next
    // magnitude bit into the ones digit.
    work_adj = work_q;
    if (work_q[WIDTH+3:WIDTH] >= 4'd5) work_adj[WIDTH+3:WIDTH] = work_q[WIDTH+3:WIDTH] + 4'd3;
    if (work_q[SW-1:WIDTH+4] >= 4'd5) work_adj[SW-1:WIDTH+4] = work_q[SW-1:WIDTH+4] + 4'd3;
    work_shift = work_adj << 1;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d = in_value[WIDTH-1];
          work_d = {8'd0, (in_value[WIDTH-1] ? neg_value : in_value)};
          cnt_d  = CW'(WIDTH);
          if (in_overflow) begin
            state_d        = DONE;
            out_sign_d     = 1'b0;
            out_tens_d     = '0;
            out_ones_d     = '0;
            out_overflow_d = 1'b1;
          end else begin
            state_d = CONVERT;
          end
        end
      end
      CONVERT: begin
        work_d = work_shift;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d        = DONE;
          out_valid_d    = 1'b1;
          out_sign_d     = sign_q;
          out_tens_d     = work_shift[SW-1:WIDTH+4];
          out_ones_d     = work_shift[WIDTH+3:WIDTH];
          out_overflow_d = 1'b0;
        end
      end
      DONE: begin
        // The overflow path enters DONE with valid still low; valid rises on
        // the following edge, and only a presented result can be consumed.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid    = out_valid_q;
  assign out_sign     = out_sign_q;
  assign out_tens     = out_tens_q;
  assign out_ones     = out_ones_q;
  assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_sub_result_bcd.sv
// Self-checking bench for sub_result_bcd with WIDTH=6.
// Expected results come from decimal arithmetic on the signed value.
module tb_sub_result_bcd;

  localparam int WIDTH = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_value = '0;
  logic             in_overflow = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_sign;
  logic [3:0]       out_tens;
  logic [3:0]       out_ones;
  logic             out_overflow;

  int checks = 0;
  int errors = 0;

  logic [10:0] obs;
  assign obs = {out_valid, out_sign, out_tens, out_ones, out_overflow};

  sub_result_bcd #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_value     (in_value),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_tens     (out_tens),
    .out_ones     (out_ones),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  // Reference: {valid, sign, tens, ones, overflow} of a presented result.
  function automatic logic [10:0] ref_result(input int v, input logic ovf);
    int m;
    m = (v < 0) ? -v : v;
    if (ovf) return {1'b1, 1'b0, 4'd0, 4'd0, 1'b1};
    return {1'b1, 1'(v < 0), 4'(m / 10), 4'(m % 10), 1'b0};
  endfunction

  // Present one input for exactly one edge (the accept edge E0); returns #1 after E0.
  task automatic accept(input int v, input logic ovf);
    in_value    = WIDTH'(v);
    in_overflow = ovf;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_overflow = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", obs, 11'd0);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_neg32;
    logic [10:0] exp;
    exp = ref_result(-32, 1'b0);
    out_ready = 1'b0;
    accept(-32, 1'b0);
    for (int k = 1; k <= WIDTH; k++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL neg32_in_ready E%0d got %b want 0", k, in_ready);
      end
      if (k < WIDTH) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL neg32_early_valid E%0d got %b want 0", k, out_valid);
        end
      end
    end
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL neg32_result got %h want %h", obs, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL neg32_release got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_sequence;
    int vals[4] = '{31, 0, -1, 10};
    int lat;
    logic [10:0] exp;
    out_ready = 1'b1;
    foreach (vals[i]) begin
      exp = ref_result(vals[i], 1'b0);
      accept(vals[i], 1'b0);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat !== WIDTH) begin
        errors++;
        $display("FAIL seq_latency v=%0d got %0d want %0d", vals[i], lat, WIDTH);
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL seq_result v=%0d got %h want %h", vals[i], obs, exp);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL seq_release v=%0d got %b want 01", vals[i], {out_valid, in_ready});
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic [10:0] exp;
    exp = ref_result(-6, 1'b1);
    out_ready = 1'b0;
    accept(-6, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_valid_E0 got %b want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL ovf_result got %h want %h", obs, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_release got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_backpressure;
    logic [10:0] exp;
    exp = ref_result(25, 1'b0);
    out_ready = 1'b0;
    accept(25, 1'b0);
    repeat (WIDTH) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_value    = WIDTH'($urandom);
      in_overflow = 1'($urandom_range(0, 1));
      checks++;
      if ({obs, in_ready} !== {exp, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got %h/%b want %h/0", k, obs, in_ready, exp);
      end
      @(posedge clk); #1;
    end
    in_valid    = 1'b0;
    in_overflow = 1'b0;
    out_ready   = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [10:0] exp;
    out_ready = 1'b1;
    accept(-17, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({obs, in_ready} !== {11'd0, 1'b1}) begin
      errors++;
      $display("FAIL rmid_after_reset got %h/%b want 000/1", obs, in_ready);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rmid_stray_valid cyc=%0d got %b want 0", k, out_valid);
      end
    end
    exp = ref_result(17, 1'b0);
    out_ready = 1'b0;
    accept(17, 1'b0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== WIDTH || obs !== exp) begin
      errors++;
      $display("FAIL rmid_17 got lat=%0d %h want lat=%0d %h", lat, obs, WIDTH, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_exhaustive;
    int a, b, diff, lat, waits;
    logic r;
    logic [10:0] exp;
    for (int v = -32; v <= 31; v++) begin
      a    = $urandom_range(0, 31);
      b    = a - v;
      diff = a - b;
      exp  = ref_result(diff, 1'b0);
      accept(diff, 1'b0);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat !== WIDTH || obs !== exp) begin
        errors++;
        $display("FAIL exh v=%0d got lat=%0d %h want lat=%0d %h", diff, lat, obs, WIDTH, exp);
      end
      waits = 0;
      do begin
        r = 1'($urandom_range(0, 1));
        if (waits > 15) r = 1'b1;
        out_ready = r;
        @(posedge clk); #1;
        waits++;
        checks++;
        if (r ? (out_valid !== 1'b0) : (obs !== exp)) begin
          errors++;
          $display("FAIL exh_hs v=%0d rdy=%b got %h want %h", diff, r, obs, r ? 11'd0 : exp);
        end
      end while (!r);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_neg32;
    test_sequence;
    test_overflow;
    test_backpressure;
    test_reset_mid;
    test_exhaustive;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
